// File: rtl/updown_count_decoder.sv
// updown_count_decoder: recovers the up/down command behind a count stream
// and keeps run-length and irregular-step statistics.
module updown_count_decoder #(
    parameter int WIDTH = 32,
    parameter int RUNW  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count,
    input  logic             count_valid,
    input  logic             clear,
    output logic [1:0]       up_down,
    output logic             dir_valid,
    output logic [WIDTH-1:0] delta,
    output logic [RUNW-1:0]  run_len,
    output logic [RUNW-1:0]  irr_cnt
);

    typedef enum logic {
        EMPTY,
        TRACK
    } state_t;

    localparam logic [RUNW-1:0] SAT = {RUNW{1'b1}};

    state_t           state;
    logic [WIDTH-1:0] prev_count;
    logic             fresh;
    logic [WIDTH-1:0] d;
    logic [1:0]       code;

    assign d = count - prev_count;

    always_comb begin
        code = 2'b11;
        unique case (1'b1)
            (d == '0):          code = 2'b00;
            (d == WIDTH'(1)):   code = 2'b01;
            (d == {WIDTH{1'b1}}): code = 2'b10;
            default:            code = 2'b11;
        endcase
    end

    // fresh marks that the next classification starts a new run
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= EMPTY;
            prev_count <= '0;
            fresh      <= 1'b0;
            up_down    <= 2'b00;
            dir_valid  <= 1'b0;
            delta      <= '0;
            run_len    <= '0;
            irr_cnt    <= '0;
        end else begin
            dir_valid <= 1'b0;
            if (clear) begin
                state   <= EMPTY;
                fresh   <= 1'b0;
                up_down <= 2'b00;
                delta   <= '0;
                run_len <= '0;
                irr_cnt <= '0;
            end else if (count_valid) begin
                prev_count <= count;
                unique case (state)
                    EMPTY: begin
                        state <= TRACK;
                        fresh <= 1'b1;
                    end
                    TRACK: begin
                        fresh     <= 1'b0;
                        up_down   <= code;
                        delta     <= d;
                        dir_valid <= 1'b1;
                        if (fresh || code != up_down)
                            run_len <= RUNW'(1);
                        else if (run_len != SAT)
                            run_len <= run_len + 1'b1;
                        if (code == 2'b11 && irr_cnt != SAT)
                            irr_cnt <= irr_cnt + 1'b1;
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_updown_count_decoder.sv
// tb_updown_count_decoder: directed vectors for updown_count_decoder
// with hand-computed expectations, RUNW=4 to reach saturation quickly.
module tb_updown_count_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] count = '0;
    logic        count_valid = 1'b0;
    logic        clear = 1'b0;
    logic [1:0]  up_down;
    logic        dir_valid;
    logic [31:0] delta;
    logic [3:0]  run_len;
    logic [3:0]  irr_cnt;

    int total = 0;
    int bad = 0;

    updown_count_decoder #(
        .WIDTH(32),
        .RUNW (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .count      (count),
        .count_valid(count_valid),
        .clear      (clear),
        .up_down    (up_down),
        .dir_valid  (dir_valid),
        .delta      (delta),
        .run_len    (run_len),
        .irr_cnt    (irr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic outs(input string tag, input logic dv,
                        input logic [1:0] ud, input logic [31:0] dl,
                        input logic [3:0] rl, input logic [3:0] ic);
        chk({tag, ".dv"}, 32'(dir_valid), 32'(dv));
        chk({tag, ".ud"}, 32'(up_down), 32'(ud));
        chk({tag, ".dl"}, delta, dl);
        chk({tag, ".rl"}, 32'(run_len), 32'(rl));
        chk({tag, ".ic"}, 32'(irr_cnt), 32'(ic));
    endtask

    task automatic step(input logic cv, input logic [31:0] c,
                        input logic clr);
        @(negedge clk);
        count_valid = cv;
        count = c;
        clear = clr;
        @(posedge clk);
        #1;
        count_valid = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        // reset and prime
        repeat (2) @(posedge clk);
        #1;
        outs("rst", 1'b0, 2'b00, 32'd0, 4'd0, 4'd0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 32'd5, 1'b0);
        outs("prime", 1'b0, 2'b00, 32'd0, 4'd0, 4'd0);

        // up run after restart
        step(1'b0, 32'd0, 1'b1);
        step(1'b1, 32'd0, 1'b0);
        outs("prime0", 1'b0, 2'b00, 32'd0, 4'd0, 4'd0);
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 32'(i), 1'b0);
            outs("up", 1'b1, 2'b01, 32'd1, 4'(i), 4'd0);
        end
        step(1'b0, 32'd99, 1'b0);
        outs("hold_cv0", 1'b0, 2'b01, 32'd1, 4'd4, 4'd0);

        // direction change and hold
        step(1'b1, 32'd4, 1'b0);
        outs("same4", 1'b1, 2'b00, 32'd0, 4'd1, 4'd0);
        step(1'b1, 32'd3, 1'b0);
        outs("dn3", 1'b1, 2'b10, 32'hFFFF_FFFF, 4'd1, 4'd0);
        step(1'b1, 32'd3, 1'b0);
        outs("h3a", 1'b1, 2'b00, 32'd0, 4'd1, 4'd0);
        step(1'b1, 32'd3, 1'b0);
        outs("h3b", 1'b1, 2'b00, 32'd0, 4'd2, 4'd0);
        step(1'b1, 32'd10, 1'b0);
        outs("irr10", 1'b1, 2'b11, 32'd7, 4'd1, 4'd1);

        // wrap-around
        step(1'b1, 32'hFFFF_FFFE, 1'b0);
        outs("w0", 1'b1, 2'b11, 32'hFFFF_FFF4, 4'd2, 4'd2);
        step(1'b1, 32'hFFFF_FFFF, 1'b0);
        outs("w1", 1'b1, 2'b01, 32'd1, 4'd1, 4'd2);
        step(1'b1, 32'd0, 1'b0);
        outs("w2", 1'b1, 2'b01, 32'd1, 4'd2, 4'd2);
        step(1'b1, 32'hFFFF_FFFF, 1'b0);
        outs("w3", 1'b1, 2'b10, 32'hFFFF_FFFF, 4'd1, 4'd2);

        // clear beats a simultaneous sample
        step(1'b1, 32'd50, 1'b1);
        outs("clr", 1'b0, 2'b00, 32'd0, 4'd0, 4'd0);
        step(1'b1, 32'd51, 1'b0);
        outs("clr51", 1'b0, 2'b00, 32'd0, 4'd0, 4'd0);
        step(1'b1, 32'd52, 1'b0);
        outs("clr52", 1'b1, 2'b01, 32'd1, 4'd1, 4'd0);

        // run_len saturation on 20 identical samples
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 32'd52, 1'b0);
            if (i == 14 || i == 15 || i == 20)
                outs("sat_run", 1'b1, 2'b00, 32'd0,
                     4'(i > 15 ? 15 : i), 4'd0);
        end

        // irr_cnt saturation on 20 irregular steps
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 32'd52 + 32'(i) * 32'd1000, 1'b0);
            if (i == 15 || i == 20)
                outs("sat_irr", 1'b1, 2'b11, 32'd1000, 4'd15, 4'd15);
        end

        // asynchronous reset between edges
        #3;
        reset = 1'b0;
        #1;
        outs("arst", 1'b0, 2'b00, 32'd0, 4'd0, 4'd0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 32'd7, 1'b0);
        outs("arst_prime", 1'b0, 2'b00, 32'd0, 4'd0, 4'd0);
        step(1'b1, 32'd8, 1'b0);
        outs("arst_up", 1'b1, 2'b01, 32'd1, 4'd1, 4'd0);
        step(1'b0, 32'd0, 1'b0);
        chk("dv_drop", 32'(dir_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
